inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, first PC fetched after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the instruction-buffer depth and the maximum number of outstanding fetches.
REQ-003 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have stall_i  input  1  downstream not accepting; hold the current output.
REQ-006 SHALL have redirect_i  input  1  taken jump/branch/flush from the control unit.
REQ-007 SHALL have redirect_addr_i  input  32  new fetch PC.
REQ-008 SHALL have imem_req_o  output  1  fetch request.
REQ-009 SHALL have imem_addr_o  output  32  fetch address, equal to the current PC.
REQ-010 SHALL have imem_gnt_i  input  1  request accepted this cycle.
REQ-011 SHALL have imem_rvalid_i  input  1  read data valid; responses are in order, at least 1 cycle after grant.
REQ-012 SHALL have imem_rdata_i  input  32  instruction word.
REQ-013 SHALL have inst_addr_o  output  32  PC of the presented instruction.
REQ-014 SHALL have inst_o  output  32  presented instruction.
REQ-015 SHALL have inst_valid_o  output  1  inst_o/inst_addr_o hold a real instruction.

Function
REQ-016 SHALL keep the PC register, outstanding count (0..DEPTH), discard count (0..DEPTH), and a DEPTH-entry FIFO of {addr, inst}.
REQ-017 SHALL assert imem_req_o iff !redirect_i and (outstanding + FIFO occupancy) < DEPTH.
REQ-018 SHALL, on req&gnt, advance the PC by 4 (modulo 2^32 wrap), increment outstanding, and enqueue the request address into an address queue.
REQ-019 SHALL, on imem_rvalid_i, decrement outstanding and pop the address queue; if discard > 0, drop the word and decrement discard; otherwise push {addr, rdata} into the FIFO.
REQ-020 SHALL drive the FIFO head on inst_addr_o/inst_o with inst_valid_o=1 when the FIFO is non-empty; when empty, SHALL drive inst_o=NOP (32'h00000013), inst_valid_o=0, and inst_addr_o holds its last value.
REQ-021 SHALL pop the head when inst_valid_o & !stall_i & !redirect_i.
REQ-022 SHALL give latency of grant in cycle N, rvalid in N+1, inst_valid_o in N+2; no combinational path from rdata to inst_o.
REQ-023 SHALL, on redirect_i, load the PC with {redirect_addr_i[31:2], 2'b00}, empty the FIFO, set discard to the outstanding count after this cycle's rvalid, and drop any rvalid arriving in that cycle.
REQ-024 SHALL give redirect priority over stall; stall SHALL NOT block issuing requests while credit remains.
REQ-025 SHALL allow a push and a pop in the same cycle when the FIFO is full, with occupancy unchanged.
REQ-026 SHALL ignore rvalid while outstanding == 0, and SHALL NOT change any counter on it (error case, no wrap).
REQ-027 SHALL, on back-to-back redirects, apply only the most recent target; the discard count SHALL never exceed DEPTH.

Reset
REQ-028 SHALL, while rst_i is high, asynchronously force PC=RESET_ADDR, outstanding=0, discard=0, FIFO empty, inst_valid_o=0, inst_o=NOP, inst_addr_o=RESET_ADDR.
REQ-029 SHALL discard responses to requests granted before a reset asserted mid-fetch; the memory side is reset together with this block.
REQ-030 SHALL assert imem_req_o with imem_addr_o=RESET_ADDR in the first cycle after rst_i deasserts.

Structure
REQ-031 SHALL take InstAddrBus, InstBus, NOP, CpuResetAddr, RstEnable and FlushEnable from the shared defines file; no local copies.
REQ-032 SHALL implement both queues with one sub-module, fetch_fifo (parameterised width/depth, registered storage, full/empty flags).

Verification
REQ-033 SHALL check reset release with gnt=1 and rvalid one cycle later: addresses 0x0, 0x4, 0x8 appear in order on inst_addr_o, starting two cycles after the first grant.
REQ-034 SHALL check stall_i held for 5 cycles with memory always granting: at most 2 requests are issued, no instruction is lost or duplicated, and output resumes with 0x8 after release.
REQ-035 SHALL check redirect to 0x100 with 2 outstanding: both stale responses are dropped, and the next valid output is addr 0x100.
REQ-036 SHALL check redirect_addr_i=0x203: imem_addr_o shows 0x200.
REQ-037 SHALL check rvalid in the same cycle as redirect: the word is dropped, and discard ends equal to the remaining outstanding count.
REQ-038 SHALL check rst_i asserted mid-fetch, asynchronously between edges: outputs go to their reset values immediately, and fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path definitions: bus widths, NOP encoding, reset/flush polarities.
// Buffered fetch entries pair an instruction word with the PC it was fetched from.
package inst_fetch_pkg;
   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;
   localparam logic [InstBus-1:0]     NOP          = 32'h0000_0013;
   localparam logic [InstAddrBus-1:0] CpuResetAddr = 32'h0000_0000;
   localparam logic RstEnable   = 1'b1;
   localparam logic FlushEnable = 1'b1;

   typedef struct packed {
      logic [InstAddrBus-1:0] addr;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

   function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] a);
      return {a[InstAddrBus-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Generic registered FIFO; data_o shows the head combinationally from storage (no bypass).
// Push is accepted when full only together with a pop; flush empties it and ignores that cycle's push.
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_pop  = pop_i && !empty_o;
   assign w_push = push_i && (!full_o || w_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i == RstEnable) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= bump(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= bump(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
   end

   assign data_o  = r_mem[r_rd_ptr];
   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited in-order requests to imem, response buffer, redirect flush.
// Grant in N, rvalid in N+1, instruction valid in N+2; stall only holds the output, never issue.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_ADDR = CpuResetAddr,
   parameter int                     DEPTH      = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [InstAddrBus-1:0] redirect_addr_i,
   output logic                   imem_req_o,
   output logic [InstAddrBus-1:0] imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [InstBus-1:0]     imem_rdata_i,
   output logic [InstAddrBus-1:0] inst_addr_o,
   output logic [InstBus-1:0]     inst_o,
   output logic                   inst_valid_o
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [InstAddrBus-1:0] r_pc;
   logic [InstAddrBus-1:0] r_last_addr;
   logic [CW-1:0]          r_outstanding;
   logic [CW-1:0]          r_discard;

   logic                   w_flush;
   logic                   w_req;
   logic                   w_fire;
   logic                   w_rv_ok;
   logic                   w_keep;
   logic                   w_pop;
   logic                   w_valid;
   logic [CW:0]            w_total;
   logic [CW-1:0]          w_out_next;
   logic [CW-1:0]          w_fifo_cnt;
   logic [CW-1:0]          w_aq_cnt;
   logic                   w_aq_full;
   logic                   w_aq_empty;
   logic                   w_dq_full;
   logic                   w_dq_empty;
   logic [InstAddrBus-1:0] w_rsp_addr;
   fetch_entry_t           w_head;
   logic                   w_unused;

   assign w_flush    = (redirect_i == FlushEnable);
   assign w_total    = {1'b0, r_outstanding} + {1'b0, w_fifo_cnt};
   assign w_req      = !w_flush && (w_total < (CW + 1)'(DEPTH));
   assign w_fire     = w_req && imem_gnt_i;
   // A response with nothing outstanding is a memory-side protocol error: ignore it entirely.
   assign w_rv_ok    = imem_rvalid_i && (r_outstanding != '0);
   assign w_keep     = w_rv_ok && (r_discard == '0) && !w_flush;
   assign w_out_next = r_outstanding + CW'(w_fire) - CW'(w_rv_ok);
   assign w_valid    = !w_dq_empty;
   assign w_pop      = w_valid && !stall_i && !w_flush;
   assign w_unused   = ^{w_aq_cnt, w_aq_full, w_aq_empty, w_dq_full};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i == RstEnable) begin
         r_pc          <= RESET_ADDR;
         r_last_addr   <= RESET_ADDR;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (w_flush) begin
            r_pc      <= align_pc(redirect_addr_i);
            r_discard <= w_out_next;
         end else begin
            if (w_fire) r_pc <= r_pc + 32'd4;
            if (w_rv_ok && (r_discard != '0)) r_discard <= r_discard - CW'(1);
         end
         if (w_valid) r_last_addr <= w_head.addr;
      end
   end

   fetch_fifo #(.WIDTH(InstAddrBus), .DEPTH(DEPTH)) u_addr_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (1'b0),
      .push_i  (w_fire),
      .data_i  (r_pc),
      .pop_i   (w_rv_ok),
      .data_o  (w_rsp_addr),
      .full_o  (w_aq_full),
      .empty_o (w_aq_empty),
      .count_o (w_aq_cnt)
   );

   fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (w_flush),
      .push_i  (w_keep),
      .data_i  ({w_rsp_addr, imem_rdata_i}),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_dq_full),
      .empty_o (w_dq_empty),
      .count_o (w_fifo_cnt)
   );

   assign imem_req_o   = w_req;
   assign imem_addr_o  = r_pc;
   assign inst_valid_o = w_valid;
   assign inst_o       = w_valid ? w_head.inst : NOP;
   assign inst_addr_o  = w_valid ? w_head.addr : r_last_addr;
endmodule
